// File: rtl/systolic_skew_buffer_if.sv
// Lane-data bus between a producer and the systolic skew buffer.
// Control and input words flow master->slave; tapped outputs and status flow back.
interface systolic_skew_buffer_if #(
    parameter int LANES = 16,
    parameter int DW    = 8
);
    logic                  en;
    logic                  flush;
    logic                  mode_req;
    logic                  in_valid;
    logic [LANES*DW-1:0]   din;
    logic [LANES*DW-1:0]   dout;
    logic [LANES-1:0]      out_valid;
    logic                  mode;
    logic                  busy;

    modport master (
        output en, flush, mode_req, in_valid, din,
        input  dout, out_valid, mode, busy
    );

    modport slave (
        input  en, flush, mode_req, in_valid, din,
        output dout, out_valid, mode, busy
    );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Per-lane delay lines that skew (lane i: DEPTH+i) or deskew (lane i: DEPTH+LANES-1-i) enabled edges.
// No backpressure: en=0 freezes all storage; flush clears in-flight words; mode only changes while idle.
// SKEW_BUFFER_ZERO_INVALID_EN: when defined, dout lanes read zero whenever their out_valid bit is low.
module systolic_skew_buffer #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    systolic_skew_buffer_if.slave sb
);
    localparam int NSTG = DEPTH + LANES - 1;

    logic [DW-1:0] data_q [LANES][NSTG];
    logic [DW-1:0] data_d [LANES][NSTG];
    logic          vld_q  [LANES][NSTG];
    logic          vld_d  [LANES][NSTG];
    logic          mode_q;
    logic          mode_d;
    logic          busy;

    logic [LANES*DW-1:0] dout_w;
    logic [LANES-1:0]    out_valid_w;

    // busy spans every stage so a word past its tap still blocks a mode change
    always_comb begin
        busy = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < NSTG; s++) begin
                busy = busy | vld_q[l][s];
            end
        end
    end

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        mode_d = busy ? mode_q : sb.mode_req;
        if (sb.flush) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < NSTG; s++) begin
                    data_d[l][s] = '0;
                    vld_d[l][s]  = 1'b0;
                end
            end
        end else if (sb.en) begin
            for (int l = 0; l < LANES; l++) begin
                data_d[l][0] = sb.din[(LANES-1-l)*DW +: DW];
                vld_d[l][0]  = sb.in_valid;
                for (int s = 1; s < NSTG; s++) begin
                    data_d[l][s] = data_q[l][s-1];
                    vld_d[l][s]  = vld_q[l][s-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < NSTG; s++) begin
                    data_q[l][s] <= '0;
                    vld_q[l][s]  <= 1'b0;
                end
            end
            mode_q <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    // Taps are constant per lane; mode only picks between the two fixed positions
    for (genvar l = 0; l < LANES; l++) begin : g_tap
        localparam int TAP_SKEW   = DEPTH - 1 + l;
        localparam int TAP_DESKEW = DEPTH - 1 + (LANES - 1 - l);

        logic          tap_vld;
        logic [DW-1:0] tap_dat;

        assign tap_vld = mode_q ? vld_q[l][TAP_DESKEW]  : vld_q[l][TAP_SKEW];
        assign tap_dat = mode_q ? data_q[l][TAP_DESKEW] : data_q[l][TAP_SKEW];

`ifdef SKEW_BUFFER_ZERO_INVALID_EN
        assign dout_w[(LANES-1-l)*DW +: DW] = tap_vld ? tap_dat : '0;
`else
        assign dout_w[(LANES-1-l)*DW +: DW] = tap_dat;
`endif
        assign out_valid_w[LANES-1-l] = tap_vld;
    end

    assign sb.dout      = dout_w;
    assign sb.out_valid = out_valid_w;
    assign sb.mode      = mode_q;
    assign sb.busy      = busy;
endmodule
